dft_peak_sequencer: RTL and testbench

Controller that finds the peak-magnitude bin of the DFT output using a single shared squarer/accumulator instead of five parallel squarers. It fetches the bins one at a time from the DFT result store over a req/ack handshake and computes |X(k)|^2 = re^2 + im^2 over two multiply cycles. It keeps a running maximum and reports the winning bin index. It sits between the DFT core's output buffer and the peak-frequency display/decode logic.

---
 rtl/dft_peak_sequencer.sv | 146 ++++++++++++++
 tb/tb_dft_peak_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/dft_peak_sequencer.sv
// dft_peak_sequencer: scans DFT bins one at a time over req/ack, squares each with
// one shared multiplier and reports the index of the largest |X(k)|^2.
// Ports:
//   clk, rst_n         rising-edge clock, synchronous active-low reset
//   start              begin a scan (sampled only in IDLE)
//   busy               high in every state except IDLE
//   bin_req, bin_idx   request for bin bin_idx towards the DFT result store
//   bin_ack            bin_re/bin_im valid this cycle (honoured only while bin_req)
//   bin_re, bin_im     signed bin components
//   done               one-cycle pulse at scan completion
//   peak_bin           winning bin index, held until the next done
//   peak_mag           winning magnitude (present only with PEAK_MAG_OUT_EN defined)
module dft_peak_sequencer #(
    parameter int DATA_W   = 67,
    parameter int NUM_BINS = 5,
    parameter int IDX_W    = 3,
    parameter int MAG_W    = 2*DATA_W+1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     busy,
    output logic                     bin_req,
    output logic [IDX_W-1:0]         bin_idx,
    input  logic                     bin_ack,
    input  logic signed [DATA_W-1:0] bin_re,
    input  logic signed [DATA_W-1:0] bin_im,
    output logic                     done,
    output logic [IDX_W-1:0]         peak_bin
`ifdef PEAK_MAG_OUT_EN
    ,output logic [MAG_W-1:0]        peak_mag
`endif
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] SQ_RE = 3'd2;
    localparam logic [2:0] SQ_IM = 3'd3;
    localparam logic [2:0] CMP   = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    logic [2:0]              state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d, pnext_q, pnext_d, peak_q, peak_d;
    logic [DATA_W-1:0]       re_q, re_d, im_q, im_d, op;
    logic [MAG_W-1:0]        acc_q, acc_d, best_q, best_d;
    logic [2*DATA_W-1:0]     sq;
    logic                    win, last;
`ifdef PEAK_MAG_OUT_EN
    logic [MAG_W-1:0]        mag_q, mag_d;
    assign peak_mag = mag_q;
`endif

    assign busy     = state_q != IDLE;
    assign bin_req  = state_q == FETCH;
    assign done     = state_q == DONE;
    assign bin_idx  = idx_q;
    assign peak_bin = peak_q;

    // Shared squarer: operands are sign-extended so the low 2*DATA_W bits of the
    // unsigned product equal the (non-negative) signed square.
    assign op   = state_q == SQ_RE ? re_q : im_q;
    assign sq   = {{DATA_W{op[DATA_W-1]}}, op} * {{DATA_W{op[DATA_W-1]}}, op};
    // Bin 0 always seeds the maximum; strict compare keeps the lower index on ties.
    assign win  = idx_q == '0 || acc_q > best_q;
    assign last = idx_q == IDX_W'(NUM_BINS-1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        re_d    = re_q;
        im_d    = im_q;
        acc_d   = acc_q;
        best_d  = best_q;
        pnext_d = pnext_q;
        peak_d  = peak_q;
`ifdef PEAK_MAG_OUT_EN
        mag_d   = mag_q;
`endif
        case (state_q)
            IDLE: if (start) begin
                idx_d   = '0;
                state_d = FETCH;
            end
            FETCH: if (bin_ack) begin
                re_d    = bin_re;
                im_d    = bin_im;
                state_d = SQ_RE;
            end
            SQ_RE: begin
                acc_d   = MAG_W'(sq);
                state_d = SQ_IM;
            end
            SQ_IM: begin
                acc_d   = acc_q + MAG_W'(sq);
                state_d = CMP;
            end
            CMP: begin
                best_d  = win ? acc_q : best_q;
                pnext_d = win ? idx_q : pnext_q;
                if (last) begin
                    // Published result includes this last bin's comparison.
                    peak_d  = pnext_d;
`ifdef PEAK_MAG_OUT_EN
                    mag_d   = best_d;
`endif
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = FETCH;
                end
            end
            DONE: begin
                idx_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            re_q    <= '0;
            im_q    <= '0;
            acc_q   <= '0;
            best_q  <= '0;
            pnext_q <= '0;
            peak_q  <= '0;
`ifdef PEAK_MAG_OUT_EN
            mag_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            re_q    <= re_d;
            im_q    <= im_d;
            acc_q   <= acc_d;
            best_q  <= best_d;
            pnext_q <= pnext_d;
            peak_q  <= peak_d;
`ifdef PEAK_MAG_OUT_EN
            mag_q   <= mag_d;
`endif
        end
    end
endmodule

// File: tb/tb_dft_peak_sequencer.sv
// tb_dft_peak_sequencer: directed and randomized scans checked against an argmax model.
module tb_dft_peak_sequencer;
    logic               clk = 0, rst_n = 0, start = 0, bin_ack = 0;
    logic               busy, bin_req, done;
    logic [2:0]         bin_idx, peak_bin;
    logic signed [66:0] bin_re = '0, bin_im = '0;
`ifdef PEAK_MAG_OUT_EN
    logic [134:0]       peak_mag;
`endif
    logic signed [66:0] re_a[5], im_a[5];
    int                 total = 0, bad = 0;
    int                 done_q[$];
    logic [2:0]         pk_q[$];
    logic [134:0]       mg_q[$];
    int                 idx_err, pk_err;
    logic               rbusy;
    logic [2:0]         rpk;

    dft_peak_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .bin_req(bin_req),
        .bin_idx(bin_idx), .bin_ack(bin_ack), .bin_re(bin_re), .bin_im(bin_im),
        .done(done), .peak_bin(peak_bin)
`ifdef PEAK_MAG_OUT_EN
        , .peak_mag(peak_mag)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [66:0] rnd67();
        return 67'({$urandom(), $urandom(), $urandom()});
    endfunction

    function automatic logic [134:0] sqr(input logic signed [66:0] v);
        logic [134:0] x;
        x = 135'(v);
        return x * x;
    endfunction

    // Reference: magnitude of every bin, first strict maximum wins.
    function automatic void model(output logic [2:0] pk, output logic [134:0] mg);
        logic [134:0] m;
        pk = '0;
        mg = '0;
        for (int k = 0; k < 5; k++) begin
            m = sqr(re_a[k]) + sqr(im_a[k]);
            if (k == 0 || m > mg) begin
                mg = m;
                pk = 3'(k);
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [134:0] got, input logic [134:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Start a scan and run ncyc cycles after the start edge, acting as the result store.
    task automatic run(input int dly, input bit spur, input bit hold, input int rst_at, input int ncyc);
        int         w;
        logic [2:0] held, prev_pk;
        logic       req_prev;
        done_q.delete(); pk_q.delete(); mg_q.delete();
        idx_err = 0; pk_err = 0; w = 0; req_prev = 0; held = '0;
        @(negedge clk);
        prev_pk = peak_bin;
        start = 1;
        @(posedge clk);
        #1 start = hold;
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge clk);
            if (done) begin
                done_q.push_back(n);
                pk_q.push_back(peak_bin);
`ifdef PEAK_MAG_OUT_EN
                mg_q.push_back(peak_mag);
`endif
            end
            if (n == rst_at + 1) begin
                rbusy = busy;
                rpk   = peak_bin;
            end else if (!done && peak_bin !== prev_pk) pk_err++;
            prev_pk = peak_bin;
            if (bin_req && req_prev && bin_idx !== held) idx_err++;
            held     = bin_idx;
            req_prev = bin_req;
            rst_n    = !(n == rst_at);
            if (bin_req) begin
                bin_ack = (w == dly);
                bin_re  = re_a[bin_idx];
                bin_im  = im_a[bin_idx];
                w       = (w == dly) ? 0 : w + 1;
            end else begin
                bin_ack = spur;
                bin_re  = rnd67();
                bin_im  = rnd67();
            end
        end
        bin_ack = 0;
        rst_n   = 1;
        start   = 0;
    endtask

    task automatic scan_check(input string tag, input int dly, input bit spur);
        logic [2:0]   pk;
        logic [134:0] mg;
        model(pk, mg);
        run(dly, spur, 0, 0, 5 * (dly + 4) + 4);
        chk({tag, "_ndone"}, 135'(done_q.size()), 135'(1));
        if (done_q.size() > 0) begin
            chk({tag, "_lat"}, 135'(done_q[0]), 135'(1 + 5 * (dly + 4)));
            chk({tag, "_peak"}, 135'(pk_q[0]), 135'(pk));
`ifdef PEAK_MAG_OUT_EN
            chk({tag, "_mag"}, mg_q[0], mg);
`endif
        end
        chk({tag, "_idxstable"}, 135'(idx_err), 135'(0));
        chk({tag, "_peakstable"}, 135'(pk_err), 135'(0));
        chk({tag, "_idle"}, 135'(busy), 135'(0));
    endtask

    task automatic set_bins(input logic signed [66:0] r0, i0, r1, i1, r2, i2, r3, i3, r4, i4);
        re_a = '{r0, r1, r2, r3, r4};
        im_a = '{i0, i1, i2, i3, i4};
    endtask

    initial begin
        logic [2:0]   pk;
        logic [134:0] mg;
        set_bins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 135'(busy), 135'(0));
        chk("rst_req", 135'(bin_req), 135'(0));
        chk("rst_idx", 135'(bin_idx), 135'(0));
        chk("rst_done", 135'(done), 135'(0));
        chk("rst_peak", 135'(peak_bin), 135'(0));
        rst_n = 1;

        set_bins(1, 0, 0, 3, 2, 2, -1, 1, 0, 0);
        scan_check("basic", 0, 0);
        chk("basic_is_bin1", 135'(peak_bin), 135'(1));

        // Abort during SQ_IM of bin 2 (cycle 11).
        run(0, 0, 0, 11, 30);
        chk("abort_busy", 135'(rbusy), 135'(0));
        chk("abort_peak", 135'(rpk), 135'(0));
        chk("abort_nodone", 135'(done_q.size()), 135'(0));
        scan_check("after_abort", 0, 0);

        set_bins(2, -2, 2, -2, 2, -2, 2, -2, 2, -2);
        scan_check("tie_all", 0, 0);
        set_bins(0, 0, 0, 0, 0, 0, 5, 0, 5, 0);
        scan_check("tie_34", 0, 0);

        set_bins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        re_a[4][66] = 1'b1;
        im_a[4][66] = 1'b1;
        scan_check("extreme", 0, 0);

        for (int k = 0; k < 5; k++) begin
            re_a[k] = rnd67();
            im_a[k] = rnd67();
        end
        scan_check("delay3_spur", 3, 1);

        // start held high: back-to-back scans 22 cycles apart, 1-cycle done pulses.
        model(pk, mg);
        run(0, 0, 1, 0, 50);
        chk("b2b_ndone", 135'(done_q.size()), 135'(2));
        if (done_q.size() == 2) begin
            chk("b2b_first", 135'(done_q[0]), 135'(21));
            chk("b2b_second", 135'(done_q[1]), 135'(43));
            chk("b2b_peak", 135'(pk_q[1]), 135'(pk));
        end
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;

        for (int t = 0; t < 8; t++) begin
            for (int k = 0; k < 5; k++) begin
                re_a[k] = t[0] ? rnd67() : 67'($signed(4'($urandom_range(0, 15))));
                im_a[k] = t[0] ? rnd67() : 67'($signed(4'($urandom_range(0, 15))));
            end
            scan_check($sformatf("rand%0d", t), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
